// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, count-width helper and operation kinds for sync_fifo_prog
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Count must represent 0..depth inclusive, hence depth+1 states.
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RW    = 2'd2,
    OP_IDLE  = 2'd3
  } fifo_op_e;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - dual-port register array, synchronous write, asynchronous read, no reset
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// rtl/sync_fifo_prog.sv - single-clock FIFO, any depth, programmable thresholds; FIFO_FWFT_EN selects fall-through read
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = calc_cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count
);

  localparam int               AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0]    LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_ok, wr_ok;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok       = rd_en && (count_q != '0);
    wr_ok       = wr_en && ((count_q != DEPTH_C) || rd_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_ok;
    overflow_d  = wr_en && !wr_ok;
    underflow_d = rd_en && !rd_ok;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; rd_en only acknowledges the pop.
  assign rd_valid = (count_q != '0);
  assign data_out = rd_valid ? mem_rdata : '0;
`else
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = rd_ok;
    if (rd_ok) begin
      data_out_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif

  assign count        = count_q;
  assign wr_ack       = wr_ack_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb/tb_sync_fifo_prog.sv - table vectors, corner sequences and queue-model random run for sync_fifo_prog
module tb_sync_fifo_prog;

  localparam int W     = 16;
  localparam int D     = 6;
  localparam int CNT_W = $clog2(D + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     data_in;
  logic             wr_en, rd_en;
  logic [CNT_W-1:0] af_thresh, ae_thresh;
  logic [W-1:0]     data_out;
  logic             rd_valid, wr_ack, overflow, underflow;
  logic             full, empty, almost_full, almost_empty;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .wr_ack       (wr_ack),
    .overflow     (overflow),
    .underflow    (underflow),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
  );

  typedef struct {
    logic         rst, wr, rd;
    logic [W-1:0] din;
    int           af, ae;
    int           cnt;
    logic         ack, ovf, udf, rv;
    logic [W-1:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic rd, logic [W-1:0] din, int cnt,
                              logic ack, logic ovf, logic udf, logic rv, logic [W-1:0] dout);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = din; v.af = 5; v.ae = 1;
    v.cnt = cnt; v.ack = ack; v.ovf = ovf; v.udf = udf; v.rv = rv; v.dout = dout;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Flag expectations come straight from occupancy and the thresholds in force.
  task automatic check_vec(input vec_t v, input string tag);
    check({tag, ".count"}, 32'(count), 32'(v.cnt));
    check({tag, ".full"}, 32'(full), 32'(v.cnt == D));
    check({tag, ".empty"}, 32'(empty), 32'(v.cnt == 0));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(v.cnt >= v.af));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(v.cnt <= v.ae));
    check({tag, ".wr_ack"}, 32'(wr_ack), 32'(v.ack));
    check({tag, ".overflow"}, 32'(overflow), 32'(v.ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(v.udf));
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(v.rv));
    check({tag, ".data_out"}, 32'(data_out), 32'(v.dout));
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; wr_en = v.wr; rd_en = v.rd; data_in = v.din;
    af_thresh = CNT_W'(v.af); ae_thresh = CNT_W'(v.ae);
    @(posedge clk);
    #1;
    check_vec(v, tag);
  endtask

  logic [W-1:0] model_q[$];

  initial begin
    vec_t v;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    af_thresh = CNT_W'(5); ae_thresh = CNT_W'(1);

    vecs.push_back(mk(1, 1, 1, 16'h1111, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 1, 1, 16'h2222, 0, 0, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 6; i++)
      vecs.push_back(mk(0, 1, 0, 16'h0A00 + 16'(i), i, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 1, 0, 16'h0A07, 6, 0, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 5, 0, 0, 0, 1, 16'h0A01));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 4, 0, 0, 0, 1, 16'h0A02));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 3, 0, 0, 0, 1, 16'h0A03));
    vecs.push_back(mk(0, 1, 0, 16'h0B01, 4, 1, 0, 0, 0, 16'h0A03));
    vecs.push_back(mk(0, 1, 0, 16'h0B02, 5, 1, 0, 0, 0, 16'h0A03));
    vecs.push_back(mk(0, 1, 0, 16'h0B03, 6, 1, 0, 0, 0, 16'h0A03));
    vecs.push_back(mk(0, 1, 1, 16'hBEEF, 6, 1, 0, 0, 1, 16'h0A04));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 5, 0, 0, 0, 1, 16'h0A05));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 4, 0, 0, 0, 1, 16'h0A06));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 3, 0, 0, 0, 1, 16'h0B01));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 2, 0, 0, 0, 1, 16'h0B02));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 1, 0, 0, 0, 1, 16'h0B03));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'hBEEF));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 0, 0, 0, 1, 0, 16'hBEEF));
    vecs.push_back(mk(0, 1, 1, 16'hC001, 1, 1, 0, 1, 0, 16'hBEEF));
    vecs.push_back(mk(0, 1, 0, 16'hC002, 2, 1, 0, 0, 0, 16'hBEEF));
    vecs.push_back(mk(0, 1, 0, 16'hC003, 3, 1, 0, 0, 0, 16'hBEEF));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Threshold change is seen without a clock edge.
    wr_en = 1'b0; rd_en = 1'b0;
    af_thresh = CNT_W'(3);
    #1;
    check("af_thresh_same_cycle", 32'(almost_full), 32'd1);

    v = mk(0, 1, 0, 16'hC004, 4, 1, 0, 0, 0, 16'hBEEF); v.af = 3;
    apply(v, "mid_write");
    v = mk(1, 1, 1, 16'hDEAD, 0, 0, 0, 0, 0, 16'h0000); v.af = 0;
    apply(v, "mid_reset");
    check("af_zero_at_reset", 32'(almost_full), 32'd1);
    apply(mk(0, 0, 1, 16'h0000, 0, 0, 0, 1, 0, 16'h0000), "post_reset_read");
    apply(mk(0, 1, 0, 16'hD001, 1, 1, 0, 0, 0, 16'h0000), "post_reset_write");
    apply(mk(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1, 16'hD001), "post_reset_pop");

    // Out-of-range thresholds: almost_full never, almost_empty always.
    for (int i = 1; i <= D; i++) begin
      v = mk(0, 1, 0, 16'hE000 + 16'(i), i, 1, 0, 0, 0, 16'hD001);
      v.af = 7; v.ae = 6;
      apply(v, $sformatf("thresh_edge%0d", i));
    end
    check("af_never_when_full", 32'(almost_full), 32'd0);
    check("ae_always_when_full", 32'(almost_empty), 32'd1);

    begin
      logic [W-1:0] exp_dout;
      logic         rd_ok, wr_ok, r, w, rd;
      exp_dout = 16'hD001;
      for (int i = 0; i < 2000; i++) begin
        int wr_pct;
        wr_pct = ((i % 400) < 200) ? 70 : 30;
        r  = (i == 0) || ($urandom_range(0, 149) == 0);
        w  = ($urandom_range(0, 99) < wr_pct);
        rd = ($urandom_range(0, 99) < (100 - wr_pct));
        v.rst = r; v.wr = w; v.rd = rd; v.din = W'($urandom);
        v.af = int'($urandom_range(0, 7)); v.ae = int'($urandom_range(0, 7));
        if (r) begin
          model_q.delete();
          exp_dout = '0;
          v.ack = 0; v.ovf = 0; v.udf = 0; v.rv = 0;
        end else begin
          rd_ok = rd && (model_q.size() > 0);
          wr_ok = w && ((model_q.size() < D) || rd_ok);
          if (rd_ok) exp_dout = model_q.pop_front();
          if (wr_ok) model_q.push_back(v.din);
          v.ack = wr_ok; v.ovf = w && !wr_ok; v.udf = rd && !rd_ok; v.rv = rd_ok;
        end
        v.cnt  = model_q.size();
        v.dout = exp_dout;
        apply(v, $sformatf("rand%0d", i));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO; the next generation of the team's single-clock FIFO. Adds:
- arbitrary (non-power-of-two) depth
- runtime-programmable almost-full/almost-empty thresholds
- an occupancy count output
- registered read-valid
Sits between producer and consumer datapaths in one clock domain.

Parameters:
FIFO_WIDTH, 16, data word width in bits (>=1)
FIFO_DEPTH, 8, number of storage words (>=2, any integer)
CNT_W, $clog2(FIFO_DEPTH+1), width of count and threshold ports (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
data_in  input  FIFO_WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request
af_thresh  input  CNT_W  almost-full threshold, sampled every cycle
ae_thresh  input  CNT_W  almost-empty threshold, sampled every cycle
data_out  output  FIFO_WIDTH  read data
rd_valid  output  1  data_out holds a newly read word
wr_ack  output  1  previous-cycle write accepted
overflow  output  1  previous-cycle write rejected
underflow  output  1  previous-cycle read rejected
full  output  1  count == FIFO_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= af_thresh
almost_empty  output  1  count <= ae_thresh
count  output  CNT_W  current occupancy

Behaviour:
Reset (rst=1 at a rising edge):
- wr_ptr, rd_ptr, count, data_out := 0
- rd_valid, wr_ack, overflow, underflow := 0
- Resulting flags: empty=1, full=0, almost_empty=1 (for any ae_thresh), almost_full=(af_thresh==0)
- Storage contents are not cleared
- Reset wins over any simultaneous wr_en/rd_en

Accept rules, evaluated on the current registered count:
- rd_ok = rd_en && count != 0
- wr_ok = wr_en && (count != FIFO_DEPTH || rd_ok). A write to a full FIFO with a simultaneous accepted read is accepted.
- Empty with wr_en && rd_en: write accepted; read rejected (underflow=1 next cycle).

Pointers:
- wr_ptr advances on wr_ok; rd_ptr advances on rd_ok.
- Each wraps from FIFO_DEPTH-1 to 0 by explicit compare (not modulo-2^n).

Count:
- count += wr_ok - rd_ok.
- Never exceeds FIFO_DEPTH; never underflows.

Read path (standard mode):
- On rd_ok: data_out <= mem[rd_ptr]; rd_valid=1 next cycle (latency 1).
- Otherwise rd_valid=0 and data_out holds its last value.

Status pulses, registered and high exactly one cycle after the request:
- wr_ack = wr_ok
- overflow = wr_en && !wr_ok
- underflow = rd_en && !rd_ok

Flags:
- full, empty, almost_full, almost_empty are combinational from the count register and threshold inputs.
- af_thresh > FIFO_DEPTH means almost_full never asserts. ae_thresh >= FIFO_DEPTH means almost_empty is always 1.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out = mem[rd_ptr] combinationally whenever count != 0.
  - rd_valid = (count != 0), combinational.
  - rd_en is a pop acknowledge.
  - A word written into an empty FIFO appears on data_out the cycle after its write.
  - Accept rules, status pulses and flags are unchanged.
- Undefined: standard registered read as above.

Decomposition:
Package fifo_pkg holds:
- default FIFO_WIDTH/FIFO_DEPTH localparams
- a CNT_W calculation function
- an enum for the bench's operation kinds (WRITE, READ, RW, IDLE)

One sub-module, fifo_mem:
- dual-port register array, FIFO_WIDTH x FIFO_DEPTH
- synchronous write port (we, waddr, wdata)
- asynchronous read port (raddr, rdata)
- No reset.

The top level owns pointers, count, flags and the read register.

Test Plan:
(WIDTH=16, DEPTH=6, af_thresh=5, ae_thresh=1)
- Reset: hold rst=1 for 2 cycles with wr_en=rd_en=1 -> empty=1, count=0, all pulses 0, data_out=0.
- Fill: write 0x0A01..0x0A06 -> wr_ack each cycle; almost_full rises when count=5; full at 6. A 7th write gives overflow=1, wr_ack=0, count stays 6.
- Drain and wrap: write 3 more after 3 reads (pointers wrap at index 5->0), then read all -> data_out order 0x0A04,0x0A05,0x0A06,new1,new2,new3. rd_valid is 1 cycle after each rd_en. Read at empty gives underflow=1.
- Full plus simultaneous rd/wr: at count=6, wr_en=rd_en=1 with data 0xBEEF -> wr_ack=1, overflow=0, count stays 6. 0xBEEF is read out 6 reads later.
- Empty plus simultaneous rd/wr: at count=0, wr_en=rd_en=1 -> wr_ack=1, underflow=1, count=1, rd_valid=0.
- Threshold change and reset mid-operation: at count=3, set af_thresh=3 -> almost_full=1 the same cycle. Assert rst with count=4 -> next cycle count=0, empty=1, and the old words never reappear on data_out.
